// File: rtl/rx_bit_timer.sv
// ============================================================================
// Module   : rx_bit_timer
// Brief    : USB receive bit recovery. An edge-resynced phase counter, mid-bit
//            sampling, NRZI decode, bit unstuffing and byte framing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PHASE = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus_sync,
  input  logic d_edge,
  input  logic enable_timer,
  output logic shift_enable,
  output logic d_orig,
  output logic byte_received,
  output logic stuff_err
);

  localparam int                  c_phase_w      = $clog2(CLKS_PER_BIT);
  localparam logic [c_phase_w-1:0] c_last_phase   = c_phase_w'(CLKS_PER_BIT - 1);
  localparam logic [c_phase_w-1:0] c_sample_phase = c_phase_w'(SAMPLE_PHASE);
  localparam logic [c_phase_w-1:0] c_resync_phase = c_phase_w'(1);
  localparam logic [2:0]           c_max_ones     = 3'd6;
  localparam logic [2:0]           c_last_bit     = 3'd7;

  generate
    if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT > 16) ||
        (SAMPLE_PHASE < 0) || (SAMPLE_PHASE >= CLKS_PER_BIT)) begin : g_bad_params
      $error("rx_bit_timer: illegal CLKS_PER_BIT / SAMPLE_PHASE combination");
    end
  endgenerate

  logic [c_phase_w-1:0] r_phase;
  logic                 r_prev_level;
  logic [2:0]           r_ones_cnt;
  logic [2:0]           r_bit_cnt;
  logic                 r_shift_enable;
  logic                 r_d_orig;
  logic                 r_byte_received;
  logic                 r_stuff_err;

  logic                 w_sample;
  logic                 w_bit;
  logic [c_phase_w-1:0] w_phase_nxt;
  logic                 w_prev_level_nxt;
  logic [2:0]           w_ones_cnt_nxt;
  logic [2:0]           w_bit_cnt_nxt;
  logic                 w_shift_enable_nxt;
  logic                 w_d_orig_nxt;
  logic                 w_byte_received_nxt;
  logic                 w_stuff_err_nxt;

  // The edge cycle itself is phase 0, so a resync loads 1 for the next cycle.
  always_comb begin
    w_sample = enable_timer && (r_phase == c_sample_phase);
    w_bit    = (d_plus_sync == r_prev_level);
  end

  always_comb begin
    w_phase_nxt = r_phase;
    if (!enable_timer) begin
      w_phase_nxt = '0;
    end else if (d_edge) begin
      w_phase_nxt = c_resync_phase;
    end else if (r_phase == c_last_phase) begin
      w_phase_nxt = '0;
    end else begin
      w_phase_nxt = r_phase + c_phase_w'(1);
    end
  end

  always_comb begin
    w_prev_level_nxt    = r_prev_level;
    w_ones_cnt_nxt      = r_ones_cnt;
    w_bit_cnt_nxt       = r_bit_cnt;
    w_shift_enable_nxt  = 1'b0;
    w_d_orig_nxt        = r_d_orig;
    w_byte_received_nxt = 1'b0;
    w_stuff_err_nxt     = 1'b0;

    if (!enable_timer) begin
      w_prev_level_nxt = 1'b1;
      w_ones_cnt_nxt   = '0;
      w_bit_cnt_nxt    = '0;
      w_d_orig_nxt     = 1'b0;
    end else if (w_sample) begin
      w_prev_level_nxt = d_plus_sync;
      if (r_ones_cnt < c_max_ones) begin
        w_shift_enable_nxt  = 1'b1;
        w_d_orig_nxt        = w_bit;
        w_ones_cnt_nxt      = w_bit ? (r_ones_cnt + 3'd1) : 3'd0;
        w_bit_cnt_nxt       = r_bit_cnt + 3'd1;
        w_byte_received_nxt = (r_bit_cnt == c_last_bit);
      end else begin
        // Seventh bit after six ones: a 0 is the stuffed bit, a 1 is a violation.
        w_ones_cnt_nxt  = '0;
        w_stuff_err_nxt = w_bit;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_phase         <= '0;
      r_prev_level    <= 1'b1;
      r_ones_cnt      <= '0;
      r_bit_cnt       <= '0;
      r_shift_enable  <= 1'b0;
      r_d_orig        <= 1'b0;
      r_byte_received <= 1'b0;
      r_stuff_err     <= 1'b0;
    end else begin
      r_phase         <= w_phase_nxt;
      r_prev_level    <= w_prev_level_nxt;
      r_ones_cnt      <= w_ones_cnt_nxt;
      r_bit_cnt       <= w_bit_cnt_nxt;
      r_shift_enable  <= w_shift_enable_nxt;
      r_d_orig        <= w_d_orig_nxt;
      r_byte_received <= w_byte_received_nxt;
      r_stuff_err     <= w_stuff_err_nxt;
    end
  end

  assign shift_enable  = r_shift_enable;
  assign d_orig        = r_d_orig;
  assign byte_received = r_byte_received;
  assign stuff_err     = r_stuff_err;

endmodule

`default_nettype wire

// File: tb/tb_rx_bit_timer.sv
// ============================================================================
// Module   : tb_rx_bit_timer
// Brief    : Drives NRZI bit streams into rx_bit_timer and scores the decoded
//            strobes against a bit-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rx_bit_timer;

  localparam int c_cpb = 8;
  localparam int c_sp  = 3;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic d_plus_sync = 1'b1;
  logic d_edge = 1'b0;
  logic enable_timer = 1'b0;
  logic shift_enable, d_orig, byte_received, stuff_err;

  rx_bit_timer #(.CLKS_PER_BIT(c_cpb), .SAMPLE_PHASE(c_sp)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .d_plus_sync   (d_plus_sync),
    .d_edge        (d_edge),
    .enable_timer  (enable_timer),
    .shift_enable  (shift_enable),
    .d_orig        (d_orig),
    .byte_received (byte_received),
    .stuff_err     (stuff_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit err;
    bit d;
    bit br;
    int t;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state (bit level, not cycle level)
  bit m_prev    = 1'b1;
  int m_ones    = 0;
  int m_bits    = 0;
  bit cur_level = 1'b1;
  int last_edge = 0;
  int since     = 0;
  int tx_ones   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_prev    = 1'b1;
    m_ones    = 0;
    m_bits    = 0;
    cur_level = 1'b1;
    tx_ones   = 0;
  endtask

  // Start one bit period; t returns the interval in which its strobe must appear.
  task automatic begin_bit(input bit level, output int t);
    exp_t e;
    bit   b;
    @(posedge clk); #1;
    d_edge       = (level != cur_level);
    d_plus_sync  = level;
    enable_timer = 1'b1;
    if (level != cur_level) begin
      last_edge = cyc;
      since     = 0;
    end else begin
      since++;
    end
    cur_level = level;
    t = last_edge + c_sp + 1 + c_cpb * since;
    b = (level == m_prev);
    m_prev = level;
    if (m_ones < 6) begin
      e.err = 1'b0; e.d = b; e.br = ((m_bits % 8) == 7); e.t = t;
      exp_q.push_back(e);
      m_bits++;
      m_ones = b ? m_ones + 1 : 0;
    end else begin
      if (b) begin
        e.err = 1'b1; e.d = 1'b0; e.br = 1'b0; e.t = t;
        exp_q.push_back(e);
      end
      m_ones = 0;
    end
  endtask

  task automatic send_level(input bit level, input int len);
    int t;
    begin_bit(level, t);
    repeat (len - 1) begin
      @(posedge clk); #1;
      d_edge = 1'b0;
    end
  endtask

  // Edge-carrying bits may be stretched or shrunk; held bits stay nominal.
  task automatic send_nrzi(input bit b, input bit drift);
    bit lvl;
    int len;
    lvl = b ? cur_level : ~cur_level;
    len = (drift && (lvl != cur_level)) ? int'($urandom_range(9, 7)) : c_cpb;
    send_level(lvl, len);
  endtask

  task automatic send_data(input bit b, input bit drift);
    send_nrzi(b, drift);
    tx_ones = b ? tx_ones + 1 : 0;
    if (tx_ones == 6) begin
      send_nrzi(1'b0, drift);
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit drift);
    for (int i = 0; i < 8; i++) send_data(v[i], drift);
  endtask

  task automatic end_packet();
    @(posedge clk); #1;
    enable_timer = 1'b0;
    d_edge       = (cur_level != 1'b1);
    d_plus_sync  = 1'b1;
    model_reset();
    repeat (6) begin
      @(posedge clk); #1;
      d_edge = 1'($urandom_range(1, 0));
    end
    d_edge = 1'b0;
    chk("queue drained", exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  bit   hold   = 1'b0;
  bit   en_prev = 1'b0;
  bit   exp_d;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!n_rst) begin
      hold    = 1'b0;
      en_prev = 1'b0;
    end else begin
      if (shift_enable || stuff_err || byte_received) begin
        if (exp_q.size() == 0) begin
          chk("unexpected output", {29'd0, shift_enable, stuff_err, byte_received}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          exp_d = mon_e.err ? hold : mon_e.d;
          chk("event flags se/err/br/d",
              {28'd0, shift_enable, stuff_err, byte_received, d_orig},
              {28'd0, ~mon_e.err, mon_e.err, mon_e.br, exp_d});
          chk("event cycle", cyc, mon_e.t);
          hold = exp_d;
        end
      end else begin
        if ((exp_q.size() > 0) && (exp_q[0].t <= cyc)) begin
          mon_e = exp_q.pop_front();
          chk("missing output se/err", {30'd0, shift_enable, stuff_err},
              mon_e.err ? 32'd1 : 32'd2);
        end
        exp_d = en_prev ? hold : 1'b0;
        chk("d_orig between strobes", d_orig, exp_d);
        hold = exp_d;
      end
      en_prev = enable_timer;
    end
  end

  initial begin
    int t;
    int guard;
    bit lvl;

    #1;
    chk("reset shift_enable", shift_enable, 0);
    chk("reset d_orig", d_orig, 0);
    chk("reset byte_received", byte_received, 0);
    chk("reset stuff_err", stuff_err, 0);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;

    // Disabled: edges must be ignored
    repeat (12) begin
      @(posedge clk); #1;
      d_edge = 1'($urandom_range(1, 0));
    end
    d_edge = 1'b0;

    // Sync byte KJKJKJKK
    send_byte(8'h80, 1'b0);
    end_packet();

    // Stuffing across a 0x7F
    send_byte(8'h80, 1'b0);
    send_byte(8'h7F, 1'b0);
    send_byte(8'hA5, 1'b0);
    end_packet();

    // Stuff violation: seven held bits, then normal zeros
    send_byte(8'h80, 1'b0);
    send_nrzi(1'b0, 1'b0);
    repeat (7) send_level(cur_level, c_cpb);
    send_nrzi(1'b0, 1'b0);
    send_nrzi(1'b1, 1'b0);
    send_nrzi(1'b0, 1'b0);
    end_packet();

    // Clock drift: every bit carries an edge and is 7..9 clocks long
    send_byte(8'h80, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    end_packet();

    // Disable after five delivered bits, then a fresh packet
    send_byte(8'h80, 1'b0);
    for (int i = 0; i < 5; i++) send_data(1'($urandom_range(1, 0)), 1'b0);
    end_packet();
    send_byte(8'h80, 1'b0);
    send_byte(8'($urandom_range(255, 0)), 1'b0);
    end_packet();

    // Asynchronous reset in the middle of a strobe
    send_byte(8'h80, 1'b0);
    begin_bit(cur_level, t);
    guard = 0;
    while ((cyc != t) && (guard < 40)) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("strobe reached before reset", cyc, t);
    chk("pre-reset shift_enable", shift_enable, 1);
    chk("pre-reset d_orig", d_orig, 1);
    n_rst = 1'b0;
    #1;
    chk("mid-packet reset shift_enable", shift_enable, 0);
    chk("mid-packet reset d_orig", d_orig, 0);
    chk("mid-packet reset byte_received", byte_received, 0);
    chk("mid-packet reset stuff_err", stuff_err, 0);
    exp_q.delete();
    model_reset();
    d_edge      = 1'b0;
    d_plus_sync = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    enable_timer = 1'b0;
    n_rst        = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      d_edge = 1'($urandom_range(1, 0));
    end
    d_edge = 1'b0;

    // Randomized packets: stuffed bytes with optional drift, then raw levels
    for (int p = 0; p < 8; p++) begin
      send_byte(8'h80, 1'b0);
      for (int n = 0; n < int'($urandom_range(3, 1)); n++)
        send_byte(8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
      if ($urandom_range(1, 0) == 1) begin
        for (int n = 0; n < 14; n++) begin
          lvl = ($urandom_range(3, 0) == 0) ? ~cur_level : cur_level;
          send_level(lvl, c_cpb);
        end
      end
      end_packet();
    end

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rx_bit_timer.md
Name: rx_bit_timer

Overview:
- Bit-recovery stage of the USB receiver. Sits directly downstream of the D+ edge detector.
- Regenerates bit timing from `d_edge` using an oversampling phase counter, samples D+ mid-bit and NRZI-decodes it.
- Removes stuffed bits and reports stuff violations.
- Delivers decoded bits with shift strobes and a byte-boundary pulse to the receive shift register and RCU.

Parameters:
- `CLKS_PER_BIT`, 8, clock cycles per USB bit time; legal range 4..16.
- `SAMPLE_PHASE`, 3, phase-counter value at which D+ is sampled; must be < `CLKS_PER_BIT`.

Ports:
- `clk` in 1: system clock, `CLKS_PER_BIT` × bit rate.
- `n_rst` in 1: asynchronous active-low reset.
- `d_plus_sync` in 1: synchronized D+ level, the same registered level fed to the edge detector.
- `d_edge` in 1: single-cycle pulse on any D+ transition, from the edge detector.
- `enable_timer` in 1: from RCU; high while a packet is being received.
- `shift_enable` out 1: single-cycle strobe; `d_orig` holds a valid data bit.
- `d_orig` out 1: NRZI-decoded, unstuffed data bit.
- `byte_received` out 1: single-cycle pulse coincident with the 8th `shift_enable` of each byte.
- `stuff_err` out 1: single-cycle pulse on a bit-stuff violation.

Behaviour:
- Reset: the clock and reset are fixed as `clk` and `n_rst`; `n_rst` is asynchronous and active-low. On reset:
  - `phase` = 0, `prev_level` = 1, `ones_cnt` = 0, `bit_cnt` = 0.
  - All outputs = 0.
  - Reset asserted mid-packet clears everything immediately; no partial byte is reported.
- Phase counter (`$clog2(CLKS_PER_BIT)` bits):
  - `enable_timer` = 0: `phase` <= 0, `prev_level` <= 1, `ones_cnt` <= 0, `bit_cnt` <= 0, all outputs <= 0.
  - `enable_timer` = 0: `d_edge` is ignored.
  - `enable_timer` = 1 and `d_edge` = 1: `phase` <= 1 (resync; the edge cycle counts as phase 0).
  - `enable_timer` = 1 and `d_edge` = 0: `phase` <= (`phase` == `CLKS_PER_BIT`-1) ? 0 : `phase`+1.
  - Sample cycle: `enable_timer` = 1 and `phase` == `SAMPLE_PHASE`. If `d_edge` = 1 in that same cycle, the sample still occurs, using the current `d_plus_sync`.
- NRZI decode, on the sample cycle:
  - `bit` = (`d_plus_sync` == `prev_level`) ? 1 : 0.
  - `prev_level` <= `d_plus_sync`.
- Unstuffing, on the sample cycle:
  - `ones_cnt` < 6: deliver the bit. `shift_enable` <= 1 and `d_orig` <= `bit`. `ones_cnt` <= `bit` ? `ones_cnt`+1 : 0.
  - `ones_cnt` == 6, `bit` = 0: stuffed bit. No `shift_enable`; `ones_cnt` <= 0; `bit_cnt` unchanged.
  - `ones_cnt` == 6, `bit` = 1: violation. `stuff_err` <= 1, no `shift_enable`, `ones_cnt` <= 0, `bit_cnt` unchanged.
- Byte counter (3 bits), on a delivered bit:
  - `bit_cnt` <= `bit_cnt`+1, wrapping 7 -> 0.
  - If `bit_cnt` == 7: `byte_received` <= 1 in the same cycle as that `shift_enable`.
- Output timing:
  - All outputs are registered and assert exactly one cycle after the sample cycle, for one cycle only.
  - `d_orig` holds its last delivered value between strobes.
  - `shift_enable` and `stuff_err` are never high together.
- Nominal latency: D+ transition -> `d_edge` (edge-detector delay) -> sample `SAMPLE_PHASE` cycles after the `d_edge` cycle -> strobe 1 cycle later.
- Long runs without edges (up to 6 ones plus the stuffed 0) free-run on the counter wrap at `CLKS_PER_BIT`.
- Data in flight:
  - Deasserting `enable_timer` mid-byte discards the partial byte and clears outputs next cycle.
  - Re-enabling starts fresh from `prev_level` = 1.

Test Plan:
- Reset and idle: `n_rst` low mid-stream with `enable_timer` = 1 -> all outputs 0 immediately. After release with `enable_timer` = 0 and `d_edge` toggling -> no strobes, `phase` stays 0.
- Sync byte: enable, then drive NRZI KJKJKJKK (D+ = 0,1,0,1,0,1,0,0) at 8 clk/bit, each bit starting with `d_edge` -> 8 `shift_enable` strobes with `d_orig` = 0,0,0,0,0,0,0,1. `byte_received` high with the 8th strobe. Each strobe falls 4 cycles after its bit's `d_edge` cycle.
- Stuffing: data 0x7F followed by further bits, with D+ holding for 6 bits then toggling once (stuffed 0) -> the stuffed bit produces no strobe. Exactly 8 strobes are produced for the next 8 data bits, and `byte_received` shifts by one bit time.
- Stuff error: D+ held constant for 7 bit times (7 ones) -> 6 strobes with `d_orig` = 1, then a single `stuff_err` pulse with no `shift_enable`. A subsequent 0 bit delivers normally with `ones_cnt` restarting.
- Clock drift: bits stretched to 9 cycles and shrunk to 7 cycles, each with `d_edge` -> resync each bit; the sample always lands at `SAMPLE_PHASE`, with no lost or duplicated strobes over 16 bits.
- Disable mid-byte: `enable_timer` dropped after 5 delivered bits, then re-raised -> outputs 0 the next cycle. The next byte produces `byte_received` only after 8 new strobes.
